multi_port_lock: RTL and testbench
==================================

MULTI_PORT_LOCK -- requirements
Module: multi_port_lock

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of requesting ports; legal range 2..16.
REQ-002 Parameter TIMEOUT, default 4096, maximum lock-hold cycles before forced release; legal range 2..65535; used only with LOCK_TIMEOUT_EN.
REQ-003 Derived constant IDX_W = max(1, clog2(NUM_PORTS)).
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_PORTS  per-port lock request, level-sensitive.
REQ-007 done  input  NUM_PORTS  per-port transfer-complete indication, sampled only for the current owner.
REQ-008 grant  output  NUM_PORTS  one-hot, registered; bit k high while port k owns the lock.
REQ-009 pend  output  NUM_PORTS  registered; bit k high while another port owns the lock.
REQ-010 owner  output  IDX_W  registered index of the current owner; holds its last value when idle.
REQ-011 busy  output  1  registered; high while any port owns the lock.
REQ-012 timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-013 FSM states: IDLE, EXEC; all outputs are registered and derived from the next state, so they change the cycle after the causing input is sampled.
REQ-014 IDLE: if any req bit is high, select the first requesting port scanning upward from rr_ptr with wrap-around, load owner, and go to EXEC; otherwise stay in IDLE.
REQ-015 EXEC: stay until done[owner] is high, then go to IDLE and load rr_ptr with (owner+1) mod NUM_PORTS.
REQ-016 Grant latency: req high in cycle n in IDLE gives grant/busy high in cycle n+1.
REQ-017 Release latency: done[owner] in cycle n gives grant/pend/busy low in cycle n+1; the earliest new grant is cycle n+2, so there is one mandatory idle cycle between owners.
REQ-018 done bits of non-owners are ignored in all states; all done bits are ignored in IDLE.
REQ-019 Dropping req[owner] during EXEC does not release the lock; only done (or timeout) releases it.
REQ-020 In EXEC, pend[k] = 1 for every k != owner and pend[owner] = 0; in IDLE, pend = 0.
REQ-021 Simultaneous req from several ports: the round-robin order from rr_ptr decides; no port waits more than NUM_PORTS-1 grants.
REQ-022 If done[owner] and req[owner] are both high in the same cycle, the lock is released; the port re-competes from IDLE at lowest round-robin priority.
REQ-023 grant is always zero or one-hot, and busy = |grant.

Reset
REQ-024 rst high forces the following immediately and asynchronously: state = IDLE, rr_ptr = 0, owner = 0, grant = 0, pend = 0, busy = 0, timeout = 0, hold counter = 0.
REQ-025 rst asserted mid-EXEC abandons the lock with no timeout pulse; the first grant after reset release follows REQ-014 from rr_ptr = 0.

Configuration
REQ-026 Macro LOCK_TIMEOUT_EN defined: a hold counter clears on entry to EXEC and increments each EXEC cycle.
REQ-027 When the hold counter reaches TIMEOUT-1 without done[owner], a forced release occurs exactly as in REQ-015, and timeout pulses for one cycle coincident with busy falling.
REQ-028 Macro LOCK_TIMEOUT_EN not defined: no hold counter is built, timeout is tied to 0, and the lock is held indefinitely until done.

Verification
REQ-029 NUM_PORTS=4, after reset, req=4'b1010 in cycle 0 -> grant=4'b0010, owner=1, pend=4'b1101, busy=1 in cycle 1.
REQ-030 Owner 1 raises done[1] with req=4'b1010 held -> cycle+1 all outputs 0; cycle+2 grant=4'b1000, owner=3.
REQ-031 All four req bits high continuously, each owner asserting done 3 cycles after grant -> grant order 0,1,2,3,0, each followed by one idle cycle.
REQ-032 Owner 2 holds the lock while done[0] and done[3] pulse -> grant stays 4'b0100 with no change.
REQ-033 With LOCK_TIMEOUT_EN, TIMEOUT=8, and no done -> busy is high for exactly 8 cycles, then timeout=1 for one cycle and grant=0; without the macro, busy stays high and timeout stays 0.
REQ-034 rst pulsed for 1 cycle during EXEC with owner=3 -> all outputs 0 immediately; the next req=4'b1001 grants port 0.

Source files
------------

// File: rtl/multi_port_lock.sv
// ---------------------------------------------------------------------------
// multi_port_lock
//
// Round-robin mutual-exclusion lock shared by NUM_PORTS requesters. An idle
// lock is granted to the first requesting port found scanning upward from
// rr_ptr, wrapping around. The owner keeps the lock until it signals done.
// After a release the lock is always idle for one cycle, and rr_ptr moves to
// the port after the old owner, so that owner ends up with the lowest priority.
//
// Optional feature (compile-time macro LOCK_TIMEOUT_EN):
//   A hold counter forces a release after TIMEOUT cycles without done, and
//   'timeout' pulses for one cycle as busy falls. Without the macro no
//   counter is built and 'timeout' is tied low.
//
// Parameters:
//   NUM_PORTS  number of requesting ports (2..16)
//   TIMEOUT    maximum lock-hold cycles (2..65535), LOCK_TIMEOUT_EN only
//
// Ports:
//   clock    in   1          rising-edge clock
//   rst      in   1          asynchronous active-high reset
//   req      in   NUM_PORTS  per-port level-sensitive lock request
//   done     in   NUM_PORTS  per-port transfer complete (owner bit only)
//   grant    out  NUM_PORTS  one-hot, bit k high while port k owns the lock
//   pend     out  NUM_PORTS  bit k high while another port owns the lock
//   owner    out  IDX_W      index of current owner, holds last value idle
//   busy     out  1          high while any port owns the lock
//   timeout  out  1          one-cycle pulse on a forced release
//
// Every output is registered and loaded with its next-state value, so each
// output changes in the cycle after the input that causes it is sampled.
// ---------------------------------------------------------------------------
module multi_port_lock #(
    parameter  int NUM_PORTS = 4,
    parameter  int TIMEOUT   = 4096,
    localparam int IDX_W     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] done,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] pend,
    output logic [IDX_W-1:0]     owner,
    output logic                 busy,
    output logic                 timeout
);

    // Out-of-range parameters are rejected when the design is elaborated.
    generate
        if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
            $error("multi_port_lock: NUM_PORTS must be in 2..16");
        end
        if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("multi_port_lock: TIMEOUT must be in 2..65535");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    pick_t            pick_r;

    // First requester at or above 'start', wrapping past the top port.
    // start + i never exceeds 2*(NUM_PORTS-1), so one extra bit is enough to
    // hold the sum before it wraps.
    function automatic pick_t rr_pick(input logic [NUM_PORTS-1:0] r,
                                      input logic [IDX_W-1:0]     start);
        pick_t          p;
        logic [IDX_W:0] cand;
        p.found = 1'b0;
        p.idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, start} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_PORTS))
                cand = cand - (IDX_W+1)'(NUM_PORTS);
            if (!p.found && r[cand[IDX_W-1:0]]) begin
                p.found = 1'b1;
                p.idx   = cand[IDX_W-1:0];
            end
        end
        return p;
    endfunction

    function automatic logic [NUM_PORTS-1:0] one_hot(input logic [IDX_W-1:0] idx);
        return {{(NUM_PORTS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // The port after the owner is first in line at the next arbitration.
    function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign pick_r = rr_pick(req, rr_ptr);

`ifdef LOCK_TIMEOUT_EN
    // 16 bits covers the largest legal TIMEOUT.
    logic [15:0] hold_cnt;

    // NOTE: state registers use non-blocking assignments only, so every
    // register in this block sees the pre-edge values of all the others.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            grant    <= '0;
            pend     <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // done is ignored while idle; only req matters here.
                    if (pick_r.found) begin
                        state    <= EXEC;
                        owner    <= pick_r.idx;
                        grant    <= one_hot(pick_r.idx);
                        pend     <= ~one_hot(pick_r.idx);
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                EXEC: begin
                    // Only the owner's done bit can release the lock. A
                    // dropped req leaves the lock held.
                    if (done[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= next_port(owner);
                        grant  <= '0;
                        pend   <= '0;
                        busy   <= 1'b0;
                    end else if (hold_cnt == 16'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        rr_ptr  <= next_port(owner);
                        grant   <= '0;
                        pend    <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign timeout = 1'b0;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            grant  <= '0;
            pend   <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_r.found) begin
                        state <= EXEC;
                        owner <= pick_r.idx;
                        grant <= one_hot(pick_r.idx);
                        pend  <= ~one_hot(pick_r.idx);
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (done[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= next_port(owner);
                        grant  <= '0;
                        pend   <= '0;
                        busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_multi_port_lock.sv
// ---------------------------------------------------------------------------
// tb_multi_port_lock
//
// Testbench for multi_port_lock with NUM_PORTS=4 and TIMEOUT=8. Each step
// drives req/done on the falling edge and runs a behavioural lock model.
// The model pushes the outputs it expects for the next cycle onto a
// scoreboard queue. After the rising edge the entry is popped and compared
// with the DUT. The scenario tasks also check specific values directly.
// ---------------------------------------------------------------------------
module tb_multi_port_lock;

    localparam int N  = 4;
    localparam int TO = 8;
`ifdef LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         rst   = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] done  = '0;
    logic [N-1:0] grant;
    logic [N-1:0] pend;
    logic [1:0]   owner;
    logic         busy;
    logic         timeout;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] pend;
        logic [1:0]   owner;
        logic         busy;
        logic         timeout;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    bit m_busy;
    int m_owner;
    int m_rr;
    int m_cnt;
    bit m_to;

    multi_port_lock #(.NUM_PORTS(N), .TIMEOUT(TO)) dut (
        .clock   (clock),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .pend    (pend),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_rr    = 0;
        m_cnt   = 0;
        m_to    = 0;
    endtask

    // One clock cycle: drive, predict, push, then pop and compare after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
        exp_t e;
        exp_t got;
        int   p;
        @(negedge clock);
        req  = r;
        done = d;
        m_to = 0;
        if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
                p = (m_rr + i) % N;
                if (r[p]) begin
                    m_busy  = 1;
                    m_owner = p;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (d[m_owner]) begin
            m_busy = 0;
            m_rr   = (m_owner + 1) % N;
        end else if (TO_EN && m_cnt == TO - 1) begin
            m_busy = 0;
            m_rr   = (m_owner + 1) % N;
            m_to   = 1;
        end else begin
            m_cnt++;
        end
        e.grant   = m_busy ? (N'(1) << m_owner) : '0;
        e.pend    = m_busy ? ~(N'(1) << m_owner) : '0;
        e.owner   = 2'(m_owner);
        e.busy    = m_busy;
        e.timeout = m_to;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        got.grant = grant; got.pend = pend; got.owner = owner;
        got.busy = busy; got.timeout = timeout;
        n_tests++;
        if ({got.grant, got.pend, got.owner, got.busy, got.timeout} !==
            {e.grant, e.pend, e.owner, e.busy, e.timeout}) begin
            n_fail++;
            $display("FAIL scoreboard @%0t: got grant=%b pend=%b owner=%0d busy=%b timeout=%b, expected grant=%b pend=%b owner=%0d busy=%b timeout=%b",
                     $time, got.grant, got.pend, got.owner, got.busy, got.timeout,
                     e.grant, e.pend, e.owner, e.busy, e.timeout);
        end
    endtask

    // Assert rst away from a clock edge and check that the outputs clear at once.
    task automatic do_reset(input string tag);
        req  = '0;
        done = '0;
        rst  = 1'b1;
        #1;
        n_tests++;
        if ({grant, pend, owner, busy, timeout} !== '0) begin
            n_fail++;
            $display("FAIL %s: during reset grant=%b pend=%b owner=%0d busy=%b timeout=%b, expected all zero",
                     tag, grant, pend, owner, busy, timeout);
        end
        @(negedge clock);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset("reset");
        step('0, '1);                      // idle, done ignored
        step('0, '0);
    endtask

    task automatic test_first_grant();
        do_reset("first_grant_reset");
        step(4'b1010, '0);
        n_tests++;
        if ({grant, owner, pend, busy} !== {4'b0010, 2'd1, 4'b1101, 1'b1}) begin
            n_fail++;
            $display("FAIL first_grant: grant=%b owner=%0d pend=%b busy=%b, expected 0010 1 1101 1",
                     grant, owner, pend, busy);
        end
    endtask

    // Continues from test_first_grant with owner 1 holding the lock.
    task automatic test_release();
        step(4'b1010, 4'b0010);
        n_tests++;
        if ({grant, pend, busy, timeout} !== '0) begin
            n_fail++;
            $display("FAIL release_idle: grant=%b pend=%b busy=%b timeout=%b, expected all zero",
                     grant, pend, busy, timeout);
        end
        step(4'b1010, '0);
        n_tests++;
        if ({grant, owner} !== {4'b1000, 2'd3}) begin
            n_fail++;
            $display("FAIL release_next: grant=%b owner=%0d, expected 1000 3", grant, owner);
        end
    endtask

    task automatic test_ignore_done();
        do_reset("ignore_done_reset");
        step(4'b0100, '0);
        step(4'b1101, 4'b1001);
        step(4'b0000, 4'b1001);            // owner drops req, lock stays
        step(4'b0000, 4'b1011);
        n_tests++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL ignore_done: grant=%b, expected 0100", grant);
        end
        step(4'b0000, 4'b0100);            // owner done releases
        step(4'b0000, 4'b1111);            // done while idle does nothing
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[$];
        logic [N-1:0] prev;
        logic [N-1:0] d;
        do_reset("rr_reset");
        exp_order = '{0, 1, 2, 3, 0};
        prev = '0;
        for (int c = 0; c < 26; c++) begin
            d = (m_busy && m_cnt == 3) ? (N'(1) << m_owner) : '0;
            step('1, d);
            if (prev == '0 && grant != '0) order.push_back(int'(owner));
            prev = grant;
        end
        n_tests++;
        if (order.size() < 5) begin
            n_fail++;
            $display("FAIL rr_count: saw %0d grants, expected at least 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (order[i] != exp_order[i]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: owner=%0d, expected %0d", i, order[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_done_and_req();
        do_reset("done_req_reset");
        step(4'b0011, '0);                 // port 0 wins
        step(4'b0011, 4'b0001);            // done with req still high
        step(4'b0011, '0);
        n_tests++;
        if (owner !== 2'd1 || grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL done_and_req: grant=%b owner=%0d, expected 0010 1", grant, owner);
        end
    endtask

    task automatic test_timeout();
        int busy_cycles;
        int to_pulses;
        bit prev_busy;
        do_reset("timeout_reset");
        busy_cycles = 0;
        to_pulses   = 0;
        prev_busy   = 0;
        step(4'b0001, '0);
        if (busy) busy_cycles++;
        prev_busy = busy;
        for (int c = 0; c < 12; c++) begin
            step('0, '0);
            if (busy) busy_cycles++;
            if (timeout) begin
                to_pulses++;
                n_tests++;
                if (!(prev_busy && !busy && grant == '0)) begin
                    n_fail++;
                    $display("FAIL timeout_edge: timeout with prev_busy=%b busy=%b grant=%b, expected 1 0 0000",
                             prev_busy, busy, grant);
                end
            end
            prev_busy = busy;
        end
        n_tests++;
        if (busy_cycles != (TO_EN ? TO : 13) || to_pulses != (TO_EN ? 1 : 0)) begin
            n_fail++;
            $display("FAIL timeout_len: busy_cycles=%0d pulses=%0d, expected %0d %0d",
                     busy_cycles, to_pulses, TO_EN ? TO : 13, TO_EN ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset("reset_mid_pre");
        step(4'b1000, '0);
        step(4'b1000, '0);
        n_tests++;
        if (owner !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_mid_owner: owner=%0d, expected 3", owner);
        end
        do_reset("reset_mid");
        step(4'b1001, '0);
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_mid_grant: grant=%b, expected 0001", grant);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] d;
        do_reset("random_reset");
        for (int c = 0; c < 300; c++) begin
            r = N'($urandom);
            d = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step(r, d);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_grant();
        test_release();
        test_ignore_done();
        test_round_robin();
        test_done_and_req();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
